// File: rtl/sme_host_ctrl.sv
// sme_host_ctrl: buffers host string/pattern bursts, replays each burst to SME
// as a contiguous strobe run and returns one registered result per pattern.
module sme_host_ctrl #(
    parameter int MAX_STR_LEN = 32,
    parameter int MAX_PAT_LEN = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    input  logic                           in_kind,
    input  logic                           in_last,
    output logic [7:0]                     sme_chardata,
    output logic                           sme_isstring,
    output logic                           sme_ispattern,
    input  logic                           sme_valid,
    input  logic                           sme_match,
    input  logic [$clog2(MAX_STR_LEN)-1:0] sme_match_index,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           res_match,
    output logic [$clog2(MAX_STR_LEN)-1:0] res_index,
    output logic [7:0]                     res_pat_id,
    output logic                           res_timeout,
    output logic                           res_err,
    output logic                           err_len,
    output logic                           busy
);
    localparam int IW = $clog2(MAX_STR_LEN);
    localparam int PW = $clog2(MAX_STR_LEN + 1);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WAIT, RESP} state_t;
    state_t          state_q, state_d;
    logic [7:0]      buf_q [MAX_STR_LEN];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      pat_id_q;
    logic            kind_q, ovf_q, str_loaded_q;
    logic            in_phase, accept, cur_kind, byte_ovf, ovf_d, play_last, timed_out;
    always_comb begin
        in_phase  = state_q == IDLE || state_q == LOAD;
        accept    = in_valid && in_ready;
        cur_kind  = state_q == IDLE ? in_kind : kind_q;
        byte_ovf  = wr_q >= (cur_kind ? PW'(MAX_PAT_LEN) : PW'(MAX_STR_LEN));
        ovf_d     = ovf_q || byte_ovf;
        play_last = rd_q + PW'(1) == wr_q;
        timed_out = cnt_q == CW'(TIMEOUT);
        state_d   = state_q;
        case (state_q)
            IDLE, LOAD: if (accept) state_d = !in_last ? LOAD :
                                              (!cur_kind && ovf_d) ? IDLE :
                                              (cur_kind && (ovf_d || !str_loaded_q)) ? RESP : PLAY;
            PLAY:       if (play_last) state_d = kind_q ? WAIT : IDLE;
            WAIT:       if (sme_valid || timed_out) state_d = RESP;
            RESP:       if (res_valid && res_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end
    // Overflowing bytes are consumed without being stored.
    always_ff @(posedge clk)
        if (accept && !byte_ovf) buf_q[wr_q[IW-1:0]] <= in_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            pat_id_q      <= '0;
            kind_q        <= 1'b0;
            ovf_q         <= 1'b0;
            str_loaded_q  <= 1'b0;
            in_ready      <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_pat_id    <= '0;
            res_timeout   <= 1'b0;
            res_err       <= 1'b0;
            err_len       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy          <= state_d != IDLE;
            in_ready      <= in_phase && !(accept && in_last);
            err_len       <= 1'b0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            case (state_q)
                IDLE, LOAD: if (accept) begin
                    kind_q <= cur_kind;
                    ovf_q  <= ovf_d;
                    rd_q   <= '0;
                    if (!byte_ovf) wr_q <= wr_q + PW'(1);
                    if (in_last && state_d == IDLE) begin
                        err_len      <= 1'b1;
                        str_loaded_q <= 1'b0;
                    end
                    if (state_d == RESP) begin
                        res_valid   <= 1'b1;
                        res_match   <= 1'b0;
                        res_index   <= '0;
                        res_timeout <= 1'b0;
                        res_err     <= 1'b1;
                        res_pat_id  <= pat_id_q;
                    end
                end
                PLAY: begin
                    sme_chardata  <= buf_q[rd_q[IW-1:0]];
                    sme_isstring  <= !kind_q;
                    sme_ispattern <= kind_q;
                    rd_q          <= rd_q + PW'(1);
                    cnt_q         <= '0;
                    if (play_last && !kind_q) begin
                        str_loaded_q <= 1'b1;
                        pat_id_q     <= '0;
                    end
                end
                WAIT: begin
                    // Counting starts on the first cycle after the pattern strobe drops.
                    cnt_q <= sme_ispattern ? '0 : cnt_q + CW'(1);
                    if (state_d == RESP) begin
                        res_valid   <= 1'b1;
                        res_match   <= sme_valid && sme_match;
                        res_index   <= (sme_valid && sme_match) ? sme_match_index : '0;
                        res_timeout <= !sme_valid;
                        res_err     <= 1'b0;
                        res_pat_id  <= pat_id_q;
                    end
                end
                RESP: if (res_valid && res_ready) begin
                    res_valid <= 1'b0;
                    pat_id_q  <= pat_id_q + 8'd1;
                end
                default: ;
            endcase
            if (state_d == IDLE) begin
                wr_q  <= '0;
                ovf_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sme_host_ctrl.md
# sme_host_ctrl

Host-side sequencer for the SME string-matching engine. It collects host byte bursts (strings and patterns) into a local buffer and replays each burst to SME as the contiguous `isstring`/`ispattern` stream SME requires. After each pattern it waits for SME's `valid` with a timeout, then returns one buffered result per pattern through a valid/ready port. It sits between the host bus adapter and a single SME instance, and shares `clk`/`reset` with SME.

## Interface
- `MAX_STR_LEN`, default 32: maximum string length in bytes; equals the `match_index` range.
- `MAX_PAT_LEN`, default 8: maximum pattern length in bytes.
- `TIMEOUT`, default 1024: number of cycles to wait for `sme_valid` after a pattern.

- `clk` input 1: single clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: host byte valid.
- `in_ready` output 1: controller can accept a byte.
- `in_data` input 8: character.
- `in_kind` input 1: 0 = string, 1 = pattern. Sampled on the first byte of a burst.
- `in_last` input 1: marks the final byte of the burst.
- `sme_chardata` output 8: character to SME.
- `sme_isstring` output 1: string stream strobe to SME.
- `sme_ispattern` output 1: pattern stream strobe to SME.
- `sme_valid` input 1: SME result strobe.
- `sme_match` input 1: SME match flag.
- `sme_match_index` input 5: SME match position.
- `res_valid` output 1: result available.
- `res_ready` input 1: host accepts the result.
- `res_match` output 1: match flag.
- `res_index` output 5: match index. Zero when `res_match` = 0.
- `res_pat_id` output 8: pattern ordinal since the last string. Wraps at 255→0.
- `res_timeout` output 1: SME gave no `valid` within `TIMEOUT` cycles.
- `res_err` output 1: pattern not run (no string loaded, or length overflow).
- `err_len` output 1: one-cycle pulse when a string burst overflows.
- `busy` output 1: state is not IDLE.

## Operation
- **Reset values.** All outputs are 0, state is IDLE, `str_loaded` = 0, `pat_id` = 0. Exception: `in_ready` = 1 in the first cycle after reset is released.
- **States.** IDLE, LOAD, PLAY, WAIT, RESP.
- **IDLE / LOAD.**
  - `in_ready` = 1.
  - A byte is accepted when `in_valid && in_ready`.
  - The first accepted byte latches `kind` and moves the state to LOAD.
  - Bytes are written into the buffer at `wr_ptr`. Gaps in `in_valid` are allowed.
  - Bytes beyond the maximum length are consumed but discarded, and set the `ovf` flag.
- **On `in_last` acceptance.**
  - String with `ovf` set: pulse `err_len`, clear `str_loaded`, go to IDLE.
  - Pattern with `ovf` set, or with `str_loaded` = 0: build a result with `res_err` = 1 and `res_match` = 0, go to RESP. SME pins are not driven.
  - Otherwise: go to PLAY.
- **PLAY.**
  - `in_ready` = 0.
  - Drive buffer[0..L-1] on `sme_chardata`, one byte per cycle, with no gaps. Hold `sme_isstring` or `sme_ispattern` (per `kind`) high for exactly L cycles.
  - After the last byte the strobe drops, and `sme_chardata` returns to 0.
  - String burst: set `str_loaded`, set `pat_id` to 0, go to IDLE.
  - Pattern burst: go to WAIT.
- **WAIT.**
  - The cycle counter starts at 0.
  - On `sme_valid`: capture `sme_match` and `sme_match_index` (index forced to 0 if `sme_match` = 0), go to RESP.
  - If the counter reaches `TIMEOUT` first: build a result with `res_timeout` = 1 and `res_match` = 0, go to RESP.
  - If `sme_valid` and the timeout occur in the same cycle, `sme_valid` wins.
- **RESP.**
  - `res_*` fields are registered and stable while `res_valid` = 1.
  - On `res_valid && res_ready`: `pat_id` increments, `res_valid` drops next cycle, go to IDLE.
  - `pat_id` increments for every pattern result, including error and timeout results.
- **Stray `sme_valid`.** An `sme_valid` seen outside WAIT is ignored.
- **String replacement.** A new string burst replaces the previous one. The SME contract requires a string before patterns.
- **Reset mid-operation.** Any state returns to IDLE next cycle. The buffer contents are don't-care. A pending result is lost.

## Timing
- **Registered outputs.** All outputs are registered. No output depends combinationally on an input.
- **Replay latency.** If `in_last` is accepted in cycle t, the first replayed byte appears on SME pins in cycle t+2. Strobes are high over cycles t+2 .. t+L+1.
- **Result latency.** If `sme_valid` is sampled high in cycle w, `res_valid` = 1 from cycle w+1.
- **Timeout latency.** `res_valid` with `res_timeout` = 1 appears `TIMEOUT`+1 cycles after the first low-strobe cycle following the pattern.
- **Error latency.** An error result (no string, or overflow) has `res_valid` = 1 in cycle t+1 after `in_last` acceptance.
- **Back-to-back bursts.** The earliest next byte acceptance is one cycle after returning to IDLE. For strings that is cycle t+L+2. For patterns it is the cycle after the result handshake.

## Test plan
1. **String then matching pattern.**
   - Stimulus: string "abcd" with `in_valid` gaps, then pattern "bc". The SME model returns `valid`, match=1, idx=1.
   - Required: `sme_isstring` high 4 contiguous cycles carrying 0x61..0x64; `sme_ispattern` high 2 cycles carrying 0x62, 0x63; result `res_match`=1, `res_index`=1, `res_pat_id`=0. A second pattern returns `res_pat_id`=1.
2. **Pattern after reset with no string.**
   - Stimulus: pattern "a" after reset.
   - Required: `res_err`=1, `res_match`=0, `res_index`=0 at t+1. SME strobes stay 0 throughout.
3. **Timeout.**
   - Stimulus: `TIMEOUT`=16; the SME model never asserts `valid`.
   - Required: `res_timeout`=1, `res_match`=0, `res_valid` rising exactly 17 cycles after `sme_ispattern` falls.
4. **Length overflow.**
   - Stimulus: 9-byte pattern, then a 33-byte string.
   - Required: all bytes accepted; the pattern gives `res_err`=1 with no SME activity; the string gives a single `err_len` pulse. A following pattern gives `res_err`=1.
5. **Result backpressure.**
   - Stimulus: `res_ready` held low for 10 cycles.
   - Required: `res_valid` and all `res_*` fields stable; `in_ready`=0; exactly one handshake occurs when `res_ready` rises.
6. **Reset mid-PLAY and simultaneous valid/timeout.**
   - Stimulus: `reset` asserted during PLAY; separately, `sme_valid` arriving in the timeout cycle.
   - Required: all outputs are 0 the cycle after reset, and a subsequent pattern returns `res_err`=1. In the simultaneous case the result carries the SME match with `res_timeout`=0.
